// File: rtl/router_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | router_pkg : shared codes for the ring router transmit path           |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

   localparam logic [2:0] tx_ACK     = 3'd0;
   localparam logic [2:0] tx_NACK    = 3'd1;
   localparam logic [2:0] tx_FORWARD = 3'd2;
   localparam logic [2:0] tx_TOKEN   = 3'd3;
   localparam logic [2:0] tx_NEW     = 3'd4;

   localparam logic [2:0] PKT_TOKEN  = 3'b111;
   localparam logic [2:0] PKT_ACK    = 3'b000;
   localparam logic [2:0] PKT_NACK   = 3'b011;
   localparam logic [2:0] PKT_DATA_C = 3'b010;
   localparam logic [2:0] PKT_DATA_3 = 3'b001;

   // Grant bit order is {token,new,fwd,nack,ack}; note NEW and TOKEN codes are swapped vs bit order.
   function automatic logic [2:0] grant_to_sel(input logic [4:0] g);
      logic [2:0] sel;
      case (g)
         5'b00001: sel = tx_ACK;
         5'b00010: sel = tx_NACK;
         5'b00100: sel = tx_FORWARD;
         5'b01000: sel = tx_NEW;
         5'b10000: sel = tx_TOKEN;
         default:  sel = tx_ACK;
      endcase
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_prio_enc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_prio_enc : one-hot winner select, ACK > NACK > {FWD,NEW} > TOKEN  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tx_prio_enc (
   input  logic [4:0] req_i,
   input  logic       rr_ptr_i,
   output logic [4:0] gnt_o
);

   // rr_ptr_i high lets NEW beat FORWARD when both are pending.
   always_comb begin
      gnt_o = 5'b00000;
      if (req_i[0])
         gnt_o = 5'b00001;
      else if (req_i[1])
         gnt_o = 5'b00010;
      else if (req_i[2] && (!rr_ptr_i || !req_i[3]))
         gnt_o = 5'b00100;
      else if (req_i[3])
         gnt_o = 5'b01000;
      else if (req_i[4])
         gnt_o = 5'b10000;
   end

endmodule
`default_nettype wire

// File: rtl/tx_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tx_sched : arbitrates transmit requests and sequences one transfer    |
// |            with a wait-state timeout. TX_SCHED_RR_EN enables FWD/NEW  |
// |            round-robin sharing.                                       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tx_sched
   import router_pkg::*;
#(
   parameter int TX_TIMEOUT = 255
) (
   input  logic       Clk_R,
   input  logic       Rst_n,
   input  logic       ack_req,
   input  logic       nack_req,
   input  logic       fwd_req,
   input  logic       new_req,
   input  logic       token_req,
   input  logic       tx_ready,
   output logic       tx_start,
   output logic [2:0] tx_data_select,
   output logic [4:0] grant,
   output logic       tx_err
);

   localparam logic [7:0] c_limit = 8'(TX_TIMEOUT - 1);

   tx_state_e  state_q;
   logic [7:0] cnt_q;
   logic       start_q;
   logic [4:0] grant_q;
   logic [2:0] sel_q;
   logic       err_q;

   logic [4:0] w_req;
   logic [4:0] w_win;
   logic       w_rr_ptr;
   logic       w_launch;

   assign w_req    = {token_req, new_req, fwd_req, nack_req, ack_req};
   assign w_launch = (state_q == ST_IDLE) && tx_ready && (|w_req);

   tx_prio_enc u_prio (
      .req_i    (w_req),
      .rr_ptr_i (w_rr_ptr),
      .gnt_o    (w_win)
   );

`ifdef TX_SCHED_RR_EN
   logic rr_q;

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n)
         rr_q <= 1'b0;
      else if (w_launch && (w_win[2] || w_win[3]))
         rr_q <= ~rr_q;
   end

   assign w_rr_ptr = rr_q;
`else
   assign w_rr_ptr = 1'b0;
`endif

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         start_q <= 1'b0;
         grant_q <= 5'b00000;
         sel_q   <= tx_ACK;
         err_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         grant_q <= 5'b00000;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_launch) begin
                  state_q <= ST_LAUNCH;
                  start_q <= 1'b1;
                  grant_q <= w_win;
                  sel_q   <= grant_to_sel(w_win);
               end else begin
                  sel_q   <= tx_ACK;
               end
            end
            ST_LAUNCH: begin
               state_q <= ST_WAIT_BUSY;
               cnt_q   <= 8'd0;
            end
            ST_WAIT_BUSY: begin
               // Timeout is checked first so it wins over a coincident tx_ready edge.
               if (cnt_q == c_limit) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                  sel_q   <= tx_ACK;
                  cnt_q   <= 8'd0;
               end else if (!tx_ready) begin
                  state_q <= ST_WAIT_DONE;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q   <= cnt_q + 8'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (cnt_q == c_limit) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                  sel_q   <= tx_ACK;
                  cnt_q   <= 8'd0;
               end else if (tx_ready) begin
                  state_q <= ST_IDLE;
                  sel_q   <= tx_ACK;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q   <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= 8'd0;
               sel_q   <= tx_ACK;
            end
         endcase
      end
   end

   assign tx_start       = start_q;
   assign grant          = grant_q;
   assign tx_data_select = sel_q;
   assign tx_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tx_sched : directed + randomized transfers against a timing model |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_tx_sched;

   localparam int T = 4;
`ifdef TX_SCHED_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   logic       Clk_R     = 1'b0;
   logic       Rst_n     = 1'b0;
   logic       ack_req   = 1'b0;
   logic       nack_req  = 1'b0;
   logic       fwd_req   = 1'b0;
   logic       new_req   = 1'b0;
   logic       token_req = 1'b0;
   logic       tx_ready  = 1'b0;
   logic       tx_start;
   logic [2:0] tx_data_select;
   logic [4:0] grant;
   logic       tx_err;

   int total = 0;
   int bad   = 0;
   bit rr_model = 1'b0;

   always #5 Clk_R = ~Clk_R;

   tx_sched #(.TX_TIMEOUT(T)) dut (
      .Clk_R          (Clk_R),
      .Rst_n          (Rst_n),
      .ack_req        (ack_req),
      .nack_req       (nack_req),
      .fwd_req        (fwd_req),
      .new_req        (new_req),
      .token_req      (token_req),
      .tx_ready       (tx_ready),
      .tx_start       (tx_start),
      .tx_data_select (tx_data_select),
      .grant          (grant),
      .tx_err         (tx_err)
   );

   task automatic tick;
      @(posedge Clk_R);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string ph, input logic e_start, input logic [4:0] e_g,
                          input logic [2:0] e_c, input logic e_err);
      chk({ph, "_start"}, 8'(tx_start), 8'(e_start));
      chk({ph, "_grant"}, 8'(grant), 8'(e_g));
      chk({ph, "_sel"}, 8'(tx_data_select), 8'(e_c));
      chk({ph, "_err"}, 8'(tx_err), 8'(e_err));
   endtask

   task automatic set_req(input logic [4:0] r);
      {token_req, new_req, fwd_req, nack_req, ack_req} = r;
   endtask

   // Request index: 0 ack, 1 nack, 2 fwd, 3 new, 4 token; shared level ordered by pointer.
   function automatic int pick(input logic [4:0] r, input bit rr);
      int order[5];
      int win;
      order = '{0, 1, rr ? 3 : 2, rr ? 2 : 3, 4};
      win = -1;
      for (int k = 4; k >= 0; k--)
         if (r[order[k]]) win = order[k];
      return win;
   endfunction

   function automatic logic [2:0] code_of(input int idx);
      logic [2:0] c;
      case (idx)
         0: c = 3'd0;
         1: c = 3'd1;
         2: c = 3'd2;
         3: c = 3'd4;
         default: c = 3'd3;
      endcase
      return c;
   endfunction

   // b: cycles tx_ready stays high after launch; d: cycles it then stays low.
   task automatic xfer(input logic [4:0] r, input int b, input int d, input bit scr);
      int w, nb, nd;
      logic [4:0] g;
      logic [2:0] c;
      bit ab_b, ab_d;
      w  = pick(r, rr_model);
      g  = 5'(1 << w);
      c  = code_of(w);
      ab_b = (b >= T - 1);
      nb   = ab_b ? T : b + 1;
      ab_d = !ab_b && (d >= T - 1);
      nd   = ab_d ? T : d + 1;
      set_req(r);
      tx_ready = 1'b1;
      tick;
      chk_out("launch", 1'b1, g, c, 1'b0);
      if (RR_ON && (w == 2 || w == 3)) rr_model = !rr_model;
      set_req(scr ? 5'($urandom) : 5'b0);
      tx_ready = 1'($urandom);
      for (int i = 0; i < nb; i++) begin
         tick;
         chk_out("busy", 1'b0, 5'b0, c, 1'b0);
         tx_ready = (i < b);
         set_req(scr ? 5'($urandom) : 5'b0);
         if (ab_b && i == nb - 1) set_req(5'b0);
      end
      if (!ab_b) begin
         for (int j = 0; j < nd; j++) begin
            tick;
            chk_out("done", 1'b0, 5'b0, c, 1'b0);
            tx_ready = (j >= d);
            set_req(scr ? 5'($urandom) : 5'b0);
            if (j == nd - 1) set_req(5'b0);
         end
      end
      tick;
      chk_out("end", 1'b0, 5'b0, 3'd0, ab_b || ab_d);
      tx_ready = 1'b1;
      tick;
      chk_out("idle", 1'b0, 5'b0, 3'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      // Reset state
      tick;
      tick;
      chk_out("reset", 1'b0, 5'b0, 3'd0, 1'b0);
      Rst_n    = 1'b1;
      tx_ready = 1'b1;
      tick;
      chk_out("post_reset", 1'b0, 5'b0, 3'd0, 1'b0);

      // FORWARD and NEW together
      xfer(5'b01100, 1, 1, 1'b0);

      // ACK beats NACK/TOKEN, then NACK beats TOKEN
      xfer(5'b10011, 1, 1, 1'b0);
      xfer(5'b10010, 1, 1, 1'b0);

      // Timeout with tx_ready held high, and both precedence corners
      xfer(5'b01000, 20, 0, 1'b0);
      xfer(5'b10000, T - 1, 0, 1'b0);
      xfer(5'b00100, T - 2, T - 1, 1'b0);
      xfer(5'b00010, T - 2, T - 2, 1'b0);
      xfer(5'b00001, 0, 0, 1'b0);

      // Requests ignored while transmitter busy in IDLE
      set_req(5'b11111);
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_out("not_ready", 1'b0, 5'b0, 3'd0, 1'b0);
      end
      set_req(5'b0);
      tx_ready = 1'b1;
      tick;

      // Reset asserted while in WAIT_DONE
      set_req(5'b00100);
      tick;
      chk_out("rst_launch", 1'b1, 5'b00100, 3'd2, 1'b0);
      set_req(5'b0);
      tx_ready = 1'b0;
      tick;
      tick;
      chk_out("rst_wdone", 1'b0, 5'b0, 3'd2, 1'b0);
      Rst_n = 1'b0;
      #1;
      chk_out("rst_async", 1'b0, 5'b0, 3'd0, 1'b0);
      rr_model = 1'b0;
      tick;
      Rst_n    = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_out("rst_release", 1'b0, 5'b0, 3'd0, 1'b0);
      end

      // FORWARD/NEW contention over four transfers
      for (int i = 0; i < 4; i++)
         xfer(5'b01100, 1, 0, 1'b0);

      // Randomized transfers with request noise during the transfer
      for (int i = 0; i < 40; i++)
         xfer(5'($urandom_range(1, 31)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 5)), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
